// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
//
// Shared definitions for the register-bank port-A arbiter:
//   ADDR_W_DEF / DATA_W_DEF : default bank geometry (16 x 8)
//   NUM_ENTRIES             : number of bank entries
//   state_t                 : arbiter transaction FSM encoding (2-bit)
//   idx_width()             : width of a binary requester index
// ---------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int NUM_ENTRIES = 16;

    // One transaction walks IDLE -> ISSUE -> WAIT -> IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // A one-requester configuration still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational grant selection for reg_bank_arbiter.
//
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  requester with highest priority this cycle
//   grant out N      one-hot grant (all zero when req is zero)
//   idx   out IDX_W  binary index of the granted requester
//   any   out 1      at least one request is present
//
// Build option REG_BANK_ARB_FIXED_PRIO_EN: lowest index always wins and ptr
// is ignored; otherwise the scan starts at ptr and wraps modulo N.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

`ifdef REG_BANK_ARB_FIXED_PRIO_EN

    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scanning downward lets the lowest set bit overwrite everything above it.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
        any = |req;
    end

`else

    // Visit positions in reverse scan order (ptr+N-1 down to ptr) so that the
    // first requester at or after ptr is the last one written and wins.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
        any = |req;
    end

`endif

endmodule

// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
//
// Shares port A of the 16x8 register bank among NUM_REQ requesters. One
// transaction is in flight at a time; each one takes IDLE (accept) -> ISSUE
// (bank samples addr/data/we) -> WAIT (bank read data valid) and is answered
// with a one-cycle rsp_valid pulse in the following IDLE cycle, i.e. three
// cycles after accept. Writes are acknowledged the same way and return the
// entry's previous contents (the bank reads before it writes).
//
// Handshake: a requester raises req_valid[i] with req_we/addr/wdata and holds
// them stable until it sees req_ready[i] high in the same cycle; that cycle
// is the accept. req_ready is combinational, one-hot, and only ever high in
// IDLE with reset released. Dropping req_valid before ready is harmless.
//
// Ports:
//   CLK, RST_N            clock (rising edge), async active-low reset
//   req_valid/req_we      per-requester request and write enable
//   req_addr/req_wdata    flattened; requester i uses slice i*W +: W
//   req_ready             one-hot accept (combinational)
//   rsp_valid/rsp_rdata   one-hot response pulse and returned data
//   bank_addr/wdata/we    drive the bank's addrA/data_inA/weA
//   bank_rdata            bank data_outA (registered, 1-cycle latency)
//   dbg_state/dbg_rr_ptr  FSM state and round-robin pointer for observation
//
// Build option REG_BANK_ARB_FIXED_PRIO_EN: fixed priority (lowest index
// wins), no rotating pointer; dbg_rr_ptr then reads 0.
// ---------------------------------------------------------------------------
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [ADDR_W-1:0]             bank_addr,
    output logic [DATA_W-1:0]             bank_wdata,
    output logic                          bank_we,
    input  logic [DATA_W-1:0]             bank_rdata,
    output state_t                        dbg_state,
    output logic [idx_width(NUM_REQ)-1:0] dbg_rr_ptr
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t             state;
    state_t             state_nxt;
    logic               grant_fire;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   arb_ptr;
    logic               arb_any;
    logic [IDX_W-1:0]   owner;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Winner's request fields, muxed out of the flattened buses.
    assign sel_addr  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
    assign sel_we    = req_we[arb_idx];

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_fire = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gating with RST_N keeps ready low for the whole reset, even though the
    // state register already reads IDLE.
    always_comb begin
        req_ready = '0;
        if (grant_fire && RST_N) begin
            req_ready = arb_grant;
        end
    end

    // -----------------------------------------------------------------------
    // State, bank drive and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            owner      <= '0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            bank_we    <= 1'b0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        bank_addr  <= sel_addr;
                        bank_wdata <= sel_wdata;
                        bank_we    <= sel_we;
                        owner      <= arb_idx;
                    end
                end
                // The bank samples during ISSUE; addr/wdata are left in place
                // until the next grant, only the write strobe is withdrawn.
                ISSUE: bank_we <= 1'b0;
                WAIT: begin
                    rsp_rdata <= bank_rdata;
                    rsp_valid <= NUM_REQ'(1) << owner;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Rotating priority pointer
    // -----------------------------------------------------------------------
`ifdef REG_BANK_ARB_FIXED_PRIO_EN

    assign arb_ptr    = '0;
    assign dbg_rr_ptr = '0;

`else

    logic [IDX_W-1:0] rr_ptr;

    // The requester just served drops to lowest priority for the next scan.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr <= '0;
        end else if (grant_fire) begin
            rr_ptr <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
    end

    assign arb_ptr    = rr_ptr;
    assign dbg_rr_ptr = rr_ptr;

`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_arbiter
//
// Bench for reg_bank_arbiter with a behavioural 16x8 bank on port A. A
// transaction-level reference (one grant at most every 3 cycles, response 3
// cycles after accept, round-robin scan over requests, memory array updated
// at accept) is advanced every cycle and compared with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_reg_bank_arbiter;
    import reg_bank_pkg::*;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we    = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   bank_addr;
    logic [DW-1:0]   bank_wdata;
    logic            bank_we;
    logic [DW-1:0]   bank_rdata = '0;
    state_t          dbg_state;
    logic [1:0]      dbg_rr_ptr;

    reg_bank_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_we    (bank_we),
        .bank_rdata (bank_rdata),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // ---------------- bank (read-before-write, registered output) ----------
    logic [DW-1:0] bank_mem [NUM_ENTRIES];
    initial for (int i = 0; i < NUM_ENTRIES; i++) bank_mem[i] = '0;
    always @(posedge CLK) begin
        bank_rdata <= bank_mem[bank_addr];
        if (bank_we) bank_mem[bank_addr] <= bank_wdata;
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            owner;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [NUM_ENTRIES];
    int            cyc = 0;
    int            next_free;
    int            ref_ptr;
    logic [DW-1:0] ref_rdata;
    logic [AW-1:0] ref_addr;
    logic [DW-1:0] ref_wdata;
    int            we_cyc;
    int            wait_cnt [N];

    logic [N-1:0]  obs_ready;
    logic [N-1:0]  obs_rsp;
    logic [DW-1:0] obs_rdata;

    initial for (int i = 0; i < NUM_ENTRIES; i++) ref_mem[i] = '0;

    task automatic model_reset();
        exp_q.delete();
        next_free = 0;
        ref_ptr   = 0;
        ref_rdata = '0;
        ref_addr  = '0;
        ref_wdata = '0;
        we_cyc    = -1;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    // First requested index at or after 'start', wrapping.
    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] we,
                        input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rsp;
        logic [AW-1:0] a_w;
        logic [DW-1:0] d_w;
        rsp_t          r;
        int            w;
        int            start;
        @(negedge CLK);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
        cyc++;
        exp_rsp = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r         = exp_q.pop_front();
            exp_rsp   = '0;
            exp_rsp[r.owner] = 1'b1;
            ref_rdata = r.data;
        end
        check("rsp_valid", rsp_valid, exp_rsp);
        check("rsp_rdata", rsp_rdata, ref_rdata);
        check("bank_we", bank_we, cyc == we_cyc);
        check("bank_addr", bank_addr, ref_addr);
        check("bank_wdata", bank_wdata, ref_wdata);
        exp_ready = '0;
        if (cyc >= next_free && v != '0) begin
`ifdef REG_BANK_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = ref_ptr;
`endif
            w = pick(v, start);
            exp_ready[w] = 1'b1;
            a_w = a[w*AW +: AW];
            d_w = d[w*DW +: DW];
            r.due   = cyc + 3;
            r.owner = w;
            r.data  = ref_mem[a_w];
            exp_q.push_back(r);
            if (we[w]) ref_mem[a_w] = d_w;
            ref_addr  = a_w;
            ref_wdata = d_w;
            we_cyc    = we[w] ? cyc + 1 : -1;
            next_free = cyc + 3;
            ref_ptr   = (w + 1) % N;
`ifndef REG_BANK_ARB_FIXED_PRIO_EN
            check("fairness", wait_cnt[w] < N, 1);
`endif
            for (int i = 0; i < N; i++) begin
                if (i == w || !v[i]) wait_cnt[i] = 0;
                else                 wait_cnt[i]++;
            end
        end else begin
            for (int i = 0; i < N; i++) if (!v[i]) wait_cnt[i] = 0;
        end
        check("req_ready", req_ready, exp_ready);
        obs_ready = req_ready;
        obs_rsp   = rsp_valid;
        obs_rdata = rsp_rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_rr_ptr", dbg_rr_ptr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_bank_we", bank_we, 0);
        check("rst_bank_addr", bank_addr, 0);
        check("rst_bank_wdata", bank_wdata, 0);
        check("rst_req_ready", req_ready, 0);
        RST_N = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [N-1:0]  valid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];
    int   glist[$];

    // Random-phase requester state.
    logic          pv  [N];
    logic          pwe [N];
    logic [AW-1:0] pa  [N];
    logic [DW-1:0] pd  [N];

    initial begin
        logic [DW-1:0] saved;
        logic [N-1:0]  v;
        logic [N-1:0]  we;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;

        // Round-robin expectations from reset (pointer 0, bank all zero).
        tbl[0] = '{4'b0001, 1'b1, 4'h3, 8'hA5, 4'b0001, 8'h00};
        tbl[1] = '{4'b0001, 1'b0, 4'h3, 8'h00, 4'b0001, 8'hA5};
        tbl[2] = '{4'b1111, 1'b0, 4'h3, 8'h00, 4'b0010, 8'hA5};
        tbl[3] = '{4'b1011, 1'b1, 4'h7, 8'h3C, 4'b1000, 8'h00};
        tbl[4] = '{4'b1010, 1'b0, 4'h7, 8'h00, 4'b0010, 8'h3C};
        tbl[5] = '{4'b0100, 1'b1, 4'hF, 8'h5A, 4'b0100, 8'h00};
        tbl[6] = '{4'b0011, 1'b0, 4'hF, 8'h00, 4'b0001, 8'h5A};
        tbl[7] = '{4'b0000, 1'b0, 4'h0, 8'h00, 4'b0000, 8'h00};
        tbl[8] = '{4'b1000, 1'b1, 4'h0, 8'hFF, 4'b1000, 8'h00};
        tbl[9] = '{4'b1000, 1'b0, 4'h0, 8'h00, 4'b1000, 8'hFF};

        model_reset();
        do_reset();

`ifndef REG_BANK_ARB_FIXED_PRIO_EN
        // Single-shot transactions, each answered three cycles after accept.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].valid, {N{tbl[i].we}}, {N{tbl[i].addr}}, {N{tbl[i].wdata}});
            check("tbl_ready", obs_ready, tbl[i].exp_ready);
            idle(3);
            check("tbl_rsp_valid", obs_rsp, tbl[i].exp_ready);
            if (tbl[i].exp_ready != '0) check("tbl_rsp_rdata", obs_rdata, tbl[i].exp_rdata);
        end

        // All four continuously valid: grants rotate 0,1,2,3, one per 3 cycles.
        do_reset();
        glist.delete();
        for (int i = 0; i < 12; i++) begin
            step(4'b1111, 4'b0000, {4'hB, 4'hA, 4'h9, 4'h8}, '0);
            if (obs_ready != '0) glist.push_back(onehot_idx(obs_ready));
        end
        idle(4);
        check("rot4_count", glist.size(), 4);
        for (int i = 0; i < glist.size() && i < 4; i++) check("rot4_order", glist[i], i);

        // Pointer at 2 with 1,2,3 valid: order 2,3,1,2.
        do_reset();
        step(4'b0010, 4'b0000, '0, '0);
        idle(3);
        glist.delete();
        for (int i = 0; i < 12; i++) begin
            step(4'b1110, 4'b0000, {4'h1, 4'h2, 4'h3, 4'h4}, '0);
            if (obs_ready != '0) glist.push_back(onehot_idx(obs_ready));
        end
        idle(4);
        check("rot3_count", glist.size(), 4);
        if (glist.size() == 4) begin
            check("rot3_g0", glist[0], 2);
            check("rot3_g1", glist[1], 3);
            check("rot3_g2", glist[2], 1);
            check("rot3_g3", glist[3], 2);
        end

        // Back-to-back: requester 0 is granted in requester 1's response cycle.
        do_reset();
        step(4'b0010, 4'b0010, {4'h0, 4'h0, 4'h7, 4'h0}, {8'h00, 8'h00, 8'h11, 8'h00});
        check("b2b_wr_ready", obs_ready, 4'b0010);
        idle(2);
        step(4'b0001, 4'b0000, {4'h0, 4'h0, 4'h0, 4'h7}, '0);
        check("b2b_wr_ack", obs_rsp, 4'b0010);
        check("b2b_wr_old", obs_rdata, 8'h3C);
        check("b2b_rd_ready", obs_ready, 4'b0001);
        idle(3);
        check("b2b_rd_rsp", obs_rsp, 4'b0001);
        check("b2b_rd_data", obs_rdata, 8'h11);
`else
        // Fixed priority: 0 and 3 continuously valid, 0 wins every grant.
        glist.delete();
        for (int i = 0; i < 12; i++) begin
            step(4'b1001, 4'b0000, {4'h6, 4'h0, 4'h0, 4'h5}, '0);
            if (obs_ready != '0) glist.push_back(onehot_idx(obs_ready));
        end
        idle(4);
        check("fp_count", glist.size(), 4);
        for (int i = 0; i < glist.size(); i++) check("fp_winner", glist[i], 0);
`endif

        // Reset during ISSUE of a write: strobe drops at once, no response.
        do_reset();
        saved = ref_mem[5];
        step(4'b0001, 4'b0001, {4'h0, 4'h0, 4'h0, 4'h5}, {8'h0, 8'h0, 8'h0, 8'h77});
        @(negedge CLK);
        req_valid = '0;
        #1;
        check("mid_issue_state", dbg_state, ISSUE);
        check("mid_issue_we", bank_we, 1);
        RST_N     = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("mid_rst_we", bank_we, 0);
        check("mid_rst_state", dbg_state, IDLE);
        check("mid_rst_ready", req_ready, 0);
        ref_mem[5] = saved;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            #1;
            check("mid_rst_rsp", rsp_valid, 0);
        end
        req_valid = '0;
        RST_N     = 1'b1;
        #1;
        check("post_rst_state", dbg_state, IDLE);
        check("post_rst_ptr", dbg_rr_ptr, 0);
        step(4'b0100, 4'b0000, {4'h0, 4'h5, 4'h0, 4'h0}, '0);
        idle(3);
        check("post_rst_rsp", obs_rsp, 4'b0100);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pv[i]  = 1'b1;
                        pwe[i] = 1'($urandom_range(0, 1));
                        pa[i]  = AW'($urandom_range(0, 5));
                        pd[i]  = DW'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                v[i]             = pv[i];
                we[i]            = pv[i] ? pwe[i] : 1'b0;
                a[i*AW +: AW]    = pa[i];
                d[i*DW +: DW]    = pd[i];
            end
            step(v, we, a, d);
            for (int i = 0; i < N; i++) if (obs_ready[i]) pv[i] = 1'b0;
        end
        idle(4);
        check("rand_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
